car_motor_seq: RTL and testbench
================================

Name: car_motor_seq

Overview:
- Downstream stage of the car obstacle controller. Consumes its go_front/go_left/go_right direction commands and drives two H-bridge motor channels.
- Sequences forward drive (PWM), fixed-length pivot turns, and a mandatory dead-time brake between direction changes.
- go_* inputs are synchronous to clk; no synchronizers are required.

Parameters:
- TURN_CYCLES, 8: length of a pivot turn in cycles (>=1).
- DEAD_CYCLES, 2: brake/dead-time cycles before any driven state (>=1).
- PWM_W, 4: PWM counter width; PWM period is 2^PWM_W cycles.
- DUTY, 12: forward duty in counts (0..2^PWM_W); 0 = always off, 2^PWM_W = always on.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- go_front  input  1  forward command.
- go_left  input  1  left-turn command.
- go_right  input  1  right-turn command.
- mot_l_pwm  output  1  left motor drive enable/PWM.
- mot_r_pwm  output  1  right motor drive enable/PWM.
- mot_l_rev  output  1  left motor reverse direction.
- mot_r_rev  output  1  right motor reverse direction.
- busy  output  1  high in DEAD, TURN_L or TURN_R.
- state  output  3  current state code.

Behaviour:
- Clock and reset:
  - One clock: clk. Reset rst_n is asynchronous and active-low.
  - While rst_n is low: state=IDLE(0); all outputs 0; PWM counter, dead counter, turn counter and target register all 0.
  - Reset mid-operation forces outputs to 0 immediately, without waiting for a clock edge.
- All outputs are registered. A command present before edge k takes effect in state and outputs from edge k onward.
- Command decode, priority front > left > right:
  - go_front=1 -> FWD.
  - else go_left=1 -> TURN_L.
  - else go_right=1 -> TURN_R.
  - else NONE.
- States and codes: IDLE=0, DEAD=1, FWD=2, TURN_L=3, TURN_R=4.
- IDLE: all pwm=0, rev=0. Any non-NONE command -> DEAD; the decoded command is latched as target.
- DEAD: all pwm=0. rev outputs take the target's values at DEAD entry, so direction settles before drive. The state stays for exactly DEAD_CYCLES cycles, then enters target. Commands during DEAD are ignored.
- FWD:
  - Both pwm = (pwm_cnt < duty); both rev=0.
  - Command FWD -> stay; NONE -> IDLE; TURN_L/TURN_R -> DEAD with new target.
- TURN_L:
  - mot_l_rev=1, mot_r_rev=0; both pwm=1 (full drive, pivot).
  - Uninterruptible for TURN_CYCLES cycles. On the last cycle, sample the command:
    - same turn -> restart the turn count and stay;
    - NONE -> IDLE;
    - otherwise -> DEAD with new target.
- TURN_R: mirror of TURN_L (mot_r_rev=1, mot_l_rev=0).
- PWM counter:
  - pwm_cnt is a free-running PWM_W-bit counter, running in all states.
  - Increments every cycle and wraps 2^PWM_W-1 -> 0.
  - duty = DUTY. Comparison is unsigned and DUTY is treated as PWM_W+1 bits, so 2^PWM_W is representable.
- Invalid state codes (5-7) recover to IDLE on the next edge.

Optional Feature:
- Macro CAR_SOFT_START_EN.
- Defined: on FWD entry the effective duty starts at 0. It increments by 1 at each pwm_cnt wrap (2^PWM_W-1 -> 0) until it reaches DUTY, then holds. The ramp register clears to 0 whenever the state is not FWD.
- Undefined: duty = DUTY immediately on FWD entry; no ramp register exists.

Test Plan:
- Reset: rst_n=0 at any time -> all outputs 0 and state=0 asynchronously. After release with no command -> remains IDLE.
- go_front held from IDLE (defaults):
  - 2 cycles DEAD with pwm=0 and rev=0;
  - then FWD, where both pwm are high for 12 of every 16 cycles, aligned to pwm_cnt<12;
  - busy=0 in FWD.
- go_left 1-cycle pulse from IDLE:
  - DEAD 2 cycles (mot_l_rev=1 already);
  - TURN_L 8 cycles with both pwm=1, mot_l_rev=1, mot_r_rev=0;
  - busy=1 for all 10 cycles; then IDLE.
- Direction change from FWD, go_right asserted:
  - next state DEAD, both pwm=0, mot_r_rev=1 for 2 cycles;
  - then TURN_R for 8 cycles.
  - Toggling go_left during the turn has no effect.
- Priority:
  - front=left=right=1 from IDLE -> target FWD.
  - left=right=1 -> TURN_L.
  - left held through a turn end -> TURN_L restarts with no DEAD.
- Async reset at cycle 3 of TURN_R -> pwm and rev drop to 0 before the next edge. After release -> IDLE. With CAR_SOFT_START_EN: FWD duty steps 0,1,2…12 over successive 16-cycle periods.

Source files
------------

// File: rtl/car_motor_seq.sv
// Motor sequencer: drives two H-bridge channels from go_front/go_left/go_right with
// PWM forward drive, fixed-length pivot turns and a dead-time brake between directions.
// Optional soft-start duty ramp in FWD is enabled by defining CAR_SOFT_START_EN.
module car_motor_seq #(
  parameter int unsigned TURN_CYCLES = 8,
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned PWM_W       = 4,
  parameter int unsigned DUTY        = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go_front,
  input  logic       go_left,
  input  logic       go_right,
  output logic       mot_l_pwm,
  output logic       mot_r_pwm,
  output logic       mot_l_rev,
  output logic       mot_r_rev,
  output logic       busy,
  output logic [2:0] state
);

  localparam int unsigned TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int unsigned DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEAD   = 3'd1;
  localparam logic [2:0] S_FWD    = 3'd2;
  localparam logic [2:0] S_TURN_L = 3'd3;
  localparam logic [2:0] S_TURN_R = 3'd4;

  localparam logic [TW-1:0]  TURN_INIT = TW'(TURN_CYCLES - 1);
  localparam logic [DW-1:0]  DEAD_INIT = DW'(DEAD_CYCLES - 1);
  localparam logic [PWM_W:0] DUTY_V    = (PWM_W + 1)'(DUTY);

  logic [2:0]       target, target_n, state_n, cmd;
  logic [TW-1:0]    turn_cnt, turn_n;
  logic [DW-1:0]    dead_cnt, dead_n;
  logic [PWM_W-1:0] pwm_cnt, pwm_cnt_n;
  logic [PWM_W:0]   duty_n;
  logic             drv_n, l_rev_n, r_rev_n, busy_n;

  // Commands share the state encoding; S_IDLE doubles as "no command".
  always_comb begin
    cmd = S_IDLE;
    if (go_front)      cmd = S_FWD;
    else if (go_left)  cmd = S_TURN_L;
    else if (go_right) cmd = S_TURN_R;
  end

  assign pwm_cnt_n = pwm_cnt + PWM_W'(1);

`ifdef CAR_SOFT_START_EN
  logic [PWM_W:0] ramp, ramp_n;

  // Ramp steps once per PWM period while staying in FWD; zero on entry.
  always_comb begin
    ramp_n = '0;
    if (state_n == S_FWD && state == S_FWD) begin
      ramp_n = ramp;
      if ((&pwm_cnt) && (ramp < DUTY_V)) ramp_n = ramp + (PWM_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ramp <= '0;
    else        ramp <= ramp_n;
  end

  assign duty_n = ramp_n;
`else
  assign duty_n = DUTY_V;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      target    <= S_IDLE;
      turn_cnt  <= '0;
      dead_cnt  <= '0;
      pwm_cnt   <= '0;
      mot_l_pwm <= 1'b0;
      mot_r_pwm <= 1'b0;
      mot_l_rev <= 1'b0;
      mot_r_rev <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      turn_cnt  <= turn_n;
      dead_cnt  <= dead_n;
      pwm_cnt   <= pwm_cnt_n;
      mot_l_pwm <= drv_n;
      mot_r_pwm <= drv_n;
      mot_l_rev <= l_rev_n;
      mot_r_rev <= r_rev_n;
      busy      <= busy_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n  = state;
    target_n = target;
    turn_n   = turn_cnt;
    dead_n   = dead_cnt;
    case (state)
      S_IDLE: begin
        if (cmd != S_IDLE) begin
          state_n  = S_DEAD;
          target_n = cmd;
          dead_n   = DEAD_INIT;
        end
      end
      S_DEAD: begin
        if (dead_cnt == '0) begin
          state_n = target;
          turn_n  = TURN_INIT;
        end else begin
          dead_n = dead_cnt - DW'(1);
        end
      end
      S_FWD: begin
        if (cmd == S_IDLE) begin
          state_n = S_IDLE;
        end else if (cmd != S_FWD) begin
          state_n  = S_DEAD;
          target_n = cmd;
          dead_n   = DEAD_INIT;
        end
      end
      S_TURN_L, S_TURN_R: begin
        if (turn_cnt != '0) begin
          turn_n = turn_cnt - TW'(1);
        end else if (cmd == state) begin
          turn_n = TURN_INIT;
        end else if (cmd == S_IDLE) begin
          state_n = S_IDLE;
        end else begin
          state_n  = S_DEAD;
          target_n = cmd;
          dead_n   = DEAD_INIT;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output values for the state being entered; DEAD pre-sets direction from the target.
  always_comb begin
    drv_n   = 1'b0;
    l_rev_n = 1'b0;
    r_rev_n = 1'b0;
    busy_n  = 1'b0;
    case (state_n)
      S_DEAD: begin
        busy_n  = 1'b1;
        l_rev_n = (target_n == S_TURN_L);
        r_rev_n = (target_n == S_TURN_R);
      end
      S_FWD:    drv_n = ({1'b0, pwm_cnt_n} < duty_n);
      S_TURN_L: begin
        busy_n  = 1'b1;
        drv_n   = 1'b1;
        l_rev_n = 1'b1;
      end
      S_TURN_R: begin
        busy_n  = 1'b1;
        drv_n   = 1'b1;
        r_rev_n = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_car_motor_seq.sv
// Directed scoreboard bench for car_motor_seq (default parameters); expected
// outputs are queued when each cycle's command is driven and compared after the edge.
module tb_car_motor_seq;

  localparam int PERIOD = 16;
  localparam int DUTY   = 12;

  logic       clk = 1'b0;
  logic       rst_n, go_front, go_left, go_right;
  logic       mot_l_pwm, mot_r_pwm, mot_l_rev, mot_r_rev, busy;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       busy;
    logic       lp;
    logic       rp;
    logic       lr;
    logic       rr;
  } obs_t;

  obs_t       q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  int         pc          = 0;
  int         ramp        = 0;
  logic [2:0] prev_st     = 3'd0;

  car_motor_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .go_front  (go_front),
    .go_left   (go_left),
    .go_right  (go_right),
    .mot_l_pwm (mot_l_pwm),
    .mot_r_pwm (mot_r_pwm),
    .mot_l_rev (mot_l_rev),
    .mot_r_rev (mot_r_rev),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  function automatic obs_t observe();
    obs_t o;
    o.st = state; o.busy = busy; o.lp = mot_l_pwm; o.rp = mot_r_pwm;
    o.lr = mot_l_rev; o.rr = mot_r_rev;
    return o;
  endfunction

  task automatic check(input obs_t e, input string tag);
    obs_t o;
    o = observe();
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed st=%0d busy=%b pwm=%b%b rev=%b%b, expected st=%0d busy=%b pwm=%b%b rev=%b%b",
             tag, o.st, o.busy, o.lp, o.rp, o.lr, o.rr, e.st, e.busy, e.lp, e.rp, e.lr, e.rr);
    end
  endtask

  // One clock: drive command, queue expectation, compare after the edge.
  // In FWD the expected drive follows the PWM counter position after the edge.
  task automatic tick(input logic f, input logic l, input logic r, input logic [2:0] st,
                      input logic drv, input logic lr, input logic rr, input string tag);
    obs_t e;
    int   pn;
    int   duty;
    go_front = f; go_left = l; go_right = r;
    pn   = (pc + 1) % PERIOD;
    duty = DUTY;
`ifdef CAR_SOFT_START_EN
    if (st == 3'd2 && prev_st == 3'd2) begin
      if (pc == PERIOD - 1 && ramp < DUTY) ramp++;
    end else begin
      ramp = 0;
    end
    duty = ramp;
`endif
    e.st   = st;
    e.busy = (st == 3'd1) || (st == 3'd3) || (st == 3'd4);
    e.lp   = (st == 3'd2) ? (pn < duty) : drv;
    e.rp   = e.lp;
    e.lr   = lr;
    e.rr   = rr;
    q.push_back(e);
    @(posedge clk);
    #1;
    pc      = pn;
    prev_st = st;
    check(q.pop_front(), tag);
  endtask

  task automatic reset_model();
    pc = 0; ramp = 0; prev_st = 3'd0;
  endtask

  initial begin
    rst_n = 1'b0; go_front = 1'b0; go_left = 1'b0; go_right = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1 check('0, "reset_hold");
    @(negedge clk) rst_n = 1'b1;
    #1;

    repeat (3) tick(0, 0, 0, 3'd0, 0, 0, 0, "idle_no_cmd");

    // Forward from IDLE: two dead cycles, then PWM at 12/16.
    tick(1, 0, 0, 3'd1, 0, 0, 0, "fwd_dead");
    tick(1, 0, 0, 3'd1, 0, 0, 0, "fwd_dead");
    repeat (36) tick(1, 0, 0, 3'd2, 0, 0, 0, "fwd_pwm");

    // FWD -> right turn through dead time; go_left toggling inside the turn is ignored.
    tick(0, 0, 1, 3'd1, 0, 0, 1, "fr_dead");
    tick(0, 0, 0, 3'd1, 0, 0, 1, "fr_dead");
    for (int i = 0; i < 8; i++) tick(0, logic'(i % 2), 0, 3'd4, 1, 0, 1, "turn_r");
    tick(0, 0, 0, 3'd0, 0, 0, 0, "turn_r_end");

    // Single-cycle left pulse.
    tick(0, 1, 0, 3'd1, 0, 1, 0, "left_dead");
    tick(0, 0, 0, 3'd1, 0, 1, 0, "left_dead");
    repeat (8) tick(0, 0, 0, 3'd3, 1, 1, 0, "turn_l");
    tick(0, 0, 0, 3'd0, 0, 0, 0, "turn_l_end");

    // All three commands: front wins; dropping to NONE in FWD returns to IDLE.
    tick(1, 1, 1, 3'd1, 0, 0, 0, "prio_all_dead");
    tick(0, 0, 0, 3'd1, 0, 0, 0, "prio_all_dead");
    tick(0, 0, 0, 3'd2, 0, 0, 0, "prio_all_fwd");
    tick(0, 0, 0, 3'd0, 0, 0, 0, "fwd_to_idle");

    // Left over right; left held across the turn end restarts without dead time.
    tick(0, 1, 1, 3'd1, 0, 1, 0, "prio_lr_dead");
    tick(0, 1, 1, 3'd1, 0, 1, 0, "prio_lr_dead");
    repeat (16) tick(0, 1, 1, 3'd3, 1, 1, 0, "turn_l_restart");
    tick(0, 0, 0, 3'd0, 0, 0, 0, "restart_end");

    // Turn end with a different command goes through dead time to the new target.
    tick(0, 0, 1, 3'd1, 0, 0, 1, "tr_dead");
    tick(0, 0, 0, 3'd1, 0, 0, 1, "tr_dead");
    repeat (7) tick(0, 0, 0, 3'd4, 1, 0, 1, "turn_r2");
    tick(1, 0, 0, 3'd4, 1, 0, 1, "turn_r2_last");
    tick(1, 0, 0, 3'd1, 0, 0, 0, "turn_to_fwd_dead");
    tick(1, 0, 0, 3'd1, 0, 0, 0, "turn_to_fwd_dead");
    repeat (4) tick(1, 0, 0, 3'd2, 0, 0, 0, "fwd_after_turn");

    // Async reset in cycle 3 of a right turn.
    tick(0, 0, 1, 3'd1, 0, 0, 1, "rst_dead");
    tick(0, 0, 0, 3'd1, 0, 0, 1, "rst_dead");
    repeat (3) tick(0, 0, 0, 3'd4, 1, 0, 1, "rst_turn_r");
    #2 rst_n = 1'b0;
    #1 check('0, "async_reset");
    reset_model();
    @(negedge clk) rst_n = 1'b1;
    #1;
    repeat (2) tick(0, 0, 0, 3'd0, 0, 0, 0, "post_reset_idle");

    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL queue_drain: observed %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
